// File: rtl/ctrl_byte_arbiter_pkg.sv
// Shared definitions for the control-unit byte arbiter: FSM state encodings
// and the two-requester round-robin selection helper.
//
// The READY_CODE parameter of ctrl_byte_arbiter must equal the controller's
// CONTROLLER_STATE_READY encoding (controller.vh), otherwise frames never end.
package ctrl_byte_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE   = 2'b00,
    ARB_STATE_LOCKED = 2'b01,
    ARB_STATE_FRAME  = 2'b10
  } arb_state_e;

  // Pick the winning source index from a 2-bit request vector; pri breaks ties.
  function automatic logic rr_select(input logic [1:0] req, input logic pri);
    logic sel;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = pri;
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_byte_arbiter.sv
// Two-source command byte arbiter in front of control_unit_seq.
// A source is granted for a whole command frame (command byte up to the
// controller returning to READY), so bytes of different sources never mix.
// Round-robin priority flips after every frame; a watchdog flags a frame that
// is starved of bytes, and a wrapping counter tallies completed frames.
module ctrl_byte_arbiter
  import ctrl_byte_arbiter_pkg::*;
#(
  parameter logic [7:0]  READY_CODE     = 8'd0,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CTR_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           src_byte_0,
  input  logic                 src_valid_0,
  output logic                 src_pop_0,
  input  logic [7:0]           src_byte_1,
  input  logic                 src_valid_1,
  output logic                 src_pop_1,
  output logic [7:0]           in_byte,
  output logic                 in_ready,
  input  logic                 next,
  input  logic [7:0]           control_state,
  output logic                 grant,
  output logic                 busy,
  output logic                 stall,
  input  logic                 stall_clear,
  output logic [CTR_WIDTH-1:0] frame_count
);

  // Timer counts up to TIMEOUT_CYCLES and parks there, so the stall set
  // condition (timer at TIMEOUT_CYCLES-1) is a single-cycle event and a
  // stall_clear during a continuing starvation is not overridden forever.
  localparam int unsigned      TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_SET = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_r;
  arb_state_e           state_s;
  logic                 grant_r;
  logic                 grant_s;
  logic                 rr_pri_r;
  logic                 stall_r;
  logic [CTR_WIDTH-1:0] frame_count_r;
  logic [TMR_W-1:0]     timer_r;

  logic                 sel_valid_s;
  logic                 ctrl_ready_s;
  logic                 owns_s;
  logic                 in_ready_s;
  logic                 frame_done_s;
  logic                 starve_s;
  logic                 stall_set_s;

  assign sel_valid_s  = grant_r ? src_valid_1 : src_valid_0;
  assign ctrl_ready_s = (control_state == READY_CODE);
  assign frame_done_s = (state_r == ARB_STATE_FRAME) && ctrl_ready_s;
  assign starve_s     = (state_r == ARB_STATE_FRAME) && !sel_valid_s && !ctrl_ready_s;
  assign stall_set_s  = starve_s && (timer_r == TMR_SET);

  // Next-state, grant decision and forwarding enables for the arbiter FSM.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    in_ready_s = 1'b0;
    owns_s     = 1'b0;
    case (state_r)
      ARB_STATE_IDLE: begin
        if (src_valid_0 || src_valid_1) begin
          grant_s = rr_select({src_valid_1, src_valid_0}, rr_pri_r);
          state_s = ARB_STATE_LOCKED;
        end else begin
          state_s = ARB_STATE_IDLE;
        end
      end
      ARB_STATE_LOCKED: begin
        owns_s     = 1'b1;
        in_ready_s = sel_valid_s;
        if (next) begin
          state_s = ARB_STATE_FRAME;
        end else begin
          state_s = ARB_STATE_LOCKED;
        end
      end
      ARB_STATE_FRAME: begin
        owns_s = 1'b1;
        // Hold off while READY so the owner cannot start a new frame unarbitrated.
        in_ready_s = sel_valid_s && !ctrl_ready_s;
        if (ctrl_ready_s) begin
          state_s = ARB_STATE_IDLE;
        end else begin
          state_s = ARB_STATE_FRAME;
        end
      end
      default: begin
        state_s = ARB_STATE_IDLE;
      end
    endcase
  end

  assign in_ready    = in_ready_s;
  assign in_byte     = grant_r ? src_byte_1 : src_byte_0;
  assign src_pop_0   = next && owns_s && !grant_r;
  assign src_pop_1   = next && owns_s && grant_r;
  assign grant       = grant_r;
  assign busy        = (state_r != ARB_STATE_IDLE);
  assign stall       = stall_r;
  assign frame_count = frame_count_r;

  // FSM state, locked grant, round-robin priority and frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ARB_STATE_IDLE;
      grant_r       <= 1'b0;
      rr_pri_r      <= 1'b0;
      frame_count_r <= {CTR_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      if (frame_done_s) begin
        rr_pri_r      <= ~grant_r;
        frame_count_r <= frame_count_r + CTR_WIDTH'(1);
      end else begin
        rr_pri_r      <= rr_pri_r;
        frame_count_r <= frame_count_r;
      end
    end
  end

  // Starvation timer: runs only inside a frame, restarts on every consumed byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= {TMR_W{1'b0}};
    end else if ((state_r != ARB_STATE_FRAME) || next) begin
      timer_r <= {TMR_W{1'b0}};
    end else if (starve_s && (timer_r != TMR_SAT)) begin
      timer_r <= timer_r + TMR_W'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Sticky stall flag; a new timeout takes precedence over a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r <= 1'b0;
    end else if (stall_set_s) begin
      stall_r <= 1'b1;
    end else if (stall_clear) begin
      stall_r <= 1'b0;
    end else begin
      stall_r <= stall_r;
    end
  end

endmodule

// File: tb/tb_ctrl_byte_arbiter.sv
// Directed bench for ctrl_byte_arbiter: two byte-FIFO source models, a small
// controller model answering in_ready with a next pulse, and a scoreboard of
// {source, byte} in the order the controller must receive them.
module tb_ctrl_byte_arbiter;

  localparam logic [7:0] READY   = 8'd0;
  localparam logic [7:0] BUSY_ST = 8'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src_byte_0, src_byte_1;
  logic        src_valid_0, src_valid_1, src_pop_0, src_pop_1;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        next_in;
  logic [7:0]  control_state = 8'd0;
  logic        grant, busy, stall;
  logic        stall_clear;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  ctrl_byte_arbiter #(
    .READY_CODE    (8'd0),
    .TIMEOUT_CYCLES(8),
    .CTR_WIDTH     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_byte_0   (src_byte_0),
    .src_valid_0  (src_valid_0),
    .src_pop_0    (src_pop_0),
    .src_byte_1   (src_byte_1),
    .src_valid_1  (src_valid_1),
    .src_pop_1    (src_pop_1),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .next         (next_in),
    .control_state(control_state),
    .grant        (grant),
    .busy         (busy),
    .stall        (stall),
    .stall_clear  (stall_clear),
    .frame_count  (frame_count)
  );

  // Source FIFO models: written by the stimulus, drained by the DUT pops.
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

  assign src_valid_0 = (rd0 != wr0);
  assign src_valid_1 = (rd1 != wr1);
  assign src_byte_0  = mem0[rd0[5:0]];
  assign src_byte_1  = mem1[rd1[5:0]];

  always @(posedge clk) begin
    if (src_pop_0) rd0 <= rd0 + 1;
    if (src_pop_1) rd1 <= rd1 + 1;
  end

  // Controller model: registered next one cycle after in_ready, 5-byte frames.
  logic next_m     = 1'b0;
  logic force_next = 1'b0;
  int   left       = 0;
  assign next_in = next_m | force_next;

  always @(posedge clk) begin
    if (!reset) begin
      next_m        <= 1'b0;
      control_state <= READY;
      left          <= 0;
    end else begin
      next_m <= in_ready && !next_m;
      if (next_m) begin
        if (control_state == READY) begin
          control_state <= BUSY_ST;
          left          <= 4;
        end else if (left == 1) begin
          control_state <= READY;
          left          <= 0;
        end else begin
          left <= left - 1;
        end
      end
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int pops0  = 0;
  int pops1  = 0;
  logic [9:0] expq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s, input logic [7:0] b);
    if (s) begin
      mem1[wr1[5:0]] = b;
      wr1++;
    end else begin
      mem0[wr0[5:0]] = b;
      wr0++;
    end
    expq.push_back({~s, s, b});
  endtask

  // One clock; sample 1 time unit after the edge and score any pop.
  task automatic cyc();
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (src_pop_0) pops0++;
    if (src_pop_1) pops1++;
    if (src_pop_0 || src_pop_1) begin
      if (expq.size() != 0) e = expq.pop_front();
      else e = 10'h000;
      check("sb_pop", {22'h0, src_pop_0, src_pop_1, in_byte}, {22'h0, e});
    end
  endtask

  task automatic wait_pops(input int target, input string tag);
    int n = 0;
    while ((pops0 + pops1) != target && n < 80) begin
      cyc();
      n++;
    end
    check(tag, 32'(pops0 + pops1), 32'(target));
  endtask

  // Called right after the last pop: READY cycle, then IDLE.
  task automatic finish_frame(input int exp_count, input string tag);
    cyc();
    check({tag, "_ready_busy"}, {31'h0, busy}, 32'h1);
    check({tag, "_ready_in_ready"}, {31'h0, in_ready}, 32'h0);
    cyc();
    check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_frame_count"}, {16'h0, frame_count}, 32'(exp_count));
  endtask

  task automatic run_frame(input logic exp_grant, input int exp_count, input string tag);
    wait_pops(pops0 + pops1 + 5, {tag, "_pops"});
    check({tag, "_grant"}, {31'h0, grant}, {31'h0, exp_grant});
    finish_frame(exp_count, tag);
  endtask

  initial begin
    reset       = 1'b0;
    stall_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_pops", {30'h0, src_pop_1, src_pop_0}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_frame_count", {16'h0, frame_count}, 32'h0);
    check("rst_grant", {31'h0, grant}, 32'h0);

    // Single source WRITE_BLOCK_REG frame on src0
    push(1'b0, 8'h02); push(1'b0, 8'h03); push(1'b0, 8'h02);
    push(1'b0, 8'h12); push(1'b0, 8'h34);
    reset = 1'b1;
    check("idle_no_forward", {31'h0, in_ready}, 32'h0);
    run_frame(1'b0, 1, "single");
    check("single_pops0", 32'(pops0), 32'd5);
    check("single_pops1", 32'(pops1), 32'd0);

    // Contention: both sources loaded while in reset
    reset = 1'b0;
    pops0 = 0;
    pops1 = 0;
    for (int i = 0; i < 5; i++) push(1'b0, 8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) push(1'b1, 8'hB0 + 8'(i));
    for (int i = 0; i < 5; i++) push(1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 5; i++) push(1'b1, 8'hD0 + 8'(i));
    cyc();
    reset = 1'b1;
    run_frame(1'b0, 1, "cont_f0");
    run_frame(1'b1, 2, "cont_f1");
    run_frame(1'b0, 3, "cont_f2");
    run_frame(1'b1, 4, "cont_f3");
    check("cont_pops0", 32'(pops0), 32'd10);
    check("cont_pops1", 32'(pops1), 32'd10);

    // Back-to-back frames from src0 only
    for (int i = 0; i < 5; i++) push(1'b0, 8'hE0 + 8'(i));
    for (int i = 0; i < 5; i++) push(1'b0, 8'hF0 + 8'(i));
    run_frame(1'b0, 5, "b2b_f0");
    check("b2b_idle_grant", {31'h0, grant}, 32'h0);
    cyc();
    check("b2b_regrant_busy", {31'h0, busy}, 32'h1);
    check("b2b_regrant_grant", {31'h0, grant}, 32'h0);
    run_frame(1'b0, 6, "b2b_f1");

    // Stray next in IDLE
    force_next = 1'b1;
    #2;
    check("stray_pops", {30'h0, src_pop_1, src_pop_0}, 32'h0);
    cyc();
    force_next = 1'b0;
    check("stray_busy", {31'h0, busy}, 32'h0);
    check("stray_frame_count", {16'h0, frame_count}, 32'd6);

    // Watchdog: src0 sends only the command byte, then starves the frame
    push(1'b0, 8'h02);
    wait_pops(pops0 + pops1 + 1, "wd_cmd_pop");
    repeat (8) cyc();
    check("wd_stall_early", {31'h0, stall}, 32'h0);
    cyc();
    check("wd_stall_set", {31'h0, stall}, 32'h1);
    stall_clear = 1'b1;
    cyc();
    stall_clear = 1'b0;
    check("wd_stall_cleared", {31'h0, stall}, 32'h0);
    repeat (3) cyc();
    check("wd_stall_stays_clear", {31'h0, stall}, 32'h0);
    check("wd_grant_held", {30'h0, busy, grant}, 32'h2);
    push(1'b0, 8'h03); push(1'b0, 8'h02); push(1'b0, 8'h12); push(1'b0, 8'h34);
    wait_pops(pops0 + pops1 + 4, "wd_resume_pops");
    finish_frame(7, "wd");

    // Async reset in the middle of a starved frame with stall raised
    push(1'b0, 8'h02); push(1'b0, 8'h55);
    wait_pops(pops0 + pops1 + 2, "ar_pops");
    repeat (9) cyc();
    check("ar_pre_stall", {31'h0, stall}, 32'h1);
    mem0[wr0[5:0]] = 8'h77;
    wr0++;
    #1;
    check("ar_pre_in_ready", {31'h0, in_ready}, 32'h1);
    check("ar_sb_empty", 32'(expq.size()), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_in_ready", {31'h0, in_ready}, 32'h0);
    check("ar_pops", {30'h0, src_pop_1, src_pop_0}, 32'h0);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_stall", {31'h0, stall}, 32'h0);
    check("ar_frame_count", {16'h0, frame_count}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
